// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential 16/8 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;
  localparam int ITER   = DEF_DW;
  localparam int CW     = $clog2(ITER);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor and subtract when it fits.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   pp,
  input  logic [VW-1:0] b,
  output logic [VW-1:0] p_next,
  output logic          qbit
);

  // A successful subtract always leaves a value below b, so the low VW bits
  // of the difference are exact and the borrow bit is never needed.
  always_comb begin
    qbit   = (pp >= {1'b0, b});
    p_next = qbit ? (pp[VW-1:0] - b) : pp[VW-1:0];
  end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on
// both the operand and result sides, divide-by-zero short-circuits to DONE.
module div_16x8_seq
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          dz
);

  state_t        state, state_n;
  logic [DW-1:0] dvd, q;
  logic [VW-1:0] dvs, r, p, p_nxt;
  logic [VW:0]   pp;
  logic [CW-1:0] cnt;
  logic          qbit, last, dz_q;

  // The stored remainder omits the 9th bit; it is always zero between steps.
  assign pp   = {p, dvd[DW-1]};
  assign last = (cnt == CW'(ITER - 1));

  div_step #(.VW(VW)) u_step (
    .pp     (pp),
    .b      (dvs),
    .p_next (p_nxt),
    .qbit   (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (B == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd  <= '0;
      dvs  <= '0;
      p    <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      dz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (B == '0) begin
              q    <= '1;
              r    <= A[VW-1:0];
              dz_q <= 1'b1;
            end else begin
              dvd  <= A;
              dvs  <= B;
              p    <= '0;
              cnt  <= '0;
              q    <= '0;
              dz_q <= 1'b0;
            end
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          p   <= p_nxt;
          q   <= {q[DW-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (last) r <= p_nxt;
        end
        default: ;
      endcase
    end
  end

  assign Q  = q;
  assign R  = r;
  assign dz = dz_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Directed-vector and randomized self-checking bench for div_16x8_seq.
module tb_div_16x8_seq;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, dz;
  logic [15:0] A, Q;
  logic [7:0]  B, R;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int res_cnt = 0;
  int n_done = 0;

  div_16x8_seq #(.DW(16), .VW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Inputs change only at posedge+1, so negedge values are what the next edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   acc_cnt++;
      if (out_valid && out_ready) res_cnt++;
      if (out_valid && in_ready)  check("valid_ready_exclusive", 1, 0);
    end
  end

  // Latency is counted in edges after the acceptance edge until out_valid is seen.
  task automatic run(input logic [15:0] a, input logic [7:0] b, input int hold,
                     input bit noise, input int exp_lat,
                     output logic [15:0] q, output logic [7:0] r, output logic d);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_issue", in_ready, 1);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("busy_not_ready", in_ready, 0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        A = 16'($urandom);
        B = 8'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    q = Q; r = R; d = dz;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_q", Q, q);
      check("hold_r", R, r);
      check("hold_dz", dz, d);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    n_done++;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        d;
    int          hold;
  } vec_t;

  vec_t tv[14];

  initial begin
    logic [15:0] q, eq;
    logic [7:0]  r, er;
    logic        d;
    int          viol;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_dz", dz, 0);

    tv[0]  = '{16'd100,   8'd7,   16'd14,    8'd2,   1'b0, 0};
    tv[1]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 0};
    tv[2]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 1};
    tv[3]  = '{16'd3,     8'd200, 16'd0,     8'd3,   1'b0, 0};
    tv[4]  = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 0};
    tv[5]  = '{16'd50000, 8'd99,  16'd505,   8'd5,   1'b0, 5};
    tv[6]  = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0, 0};
    tv[7]  = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 0};
    tv[8]  = '{16'd65535, 8'd128, 16'd511,   8'd127, 1'b0, 2};
    tv[9]  = '{16'd1000,  8'd10,  16'd100,   8'd0,   1'b0, 0};
    tv[10] = '{16'd0,     8'd0,   16'hFFFF,  8'd0,   1'b1, 3};
    tv[11] = '{16'd65535, 8'd0,   16'hFFFF,  8'hFF,  1'b1, 0};
    tv[12] = '{16'd12345, 8'd67,  16'd184,   8'd17,  1'b0, 0};
    tv[13] = '{16'd4000,  8'd13,  16'd307,   8'd9,   1'b0, 0};

    for (int i = 0; i < 14; i++) begin
      run(tv[i].a, tv[i].b, tv[i].hold, 1'b0, (tv[i].b == 0) ? 0 : 16, q, r, d);
      check("vec_q", q, tv[i].q);
      check("vec_r", r, tv[i].r);
      check("vec_dz", d, tv[i].d);
    end

    // Reset lands on the 8th CALC cycle; the in-flight result must vanish.
    A = 16'd4000; B = 8'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_q", Q, 0);
    check("midrst_r", R, 0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) viol++;
    end
    check("midrst_no_result", viol, 0);
    run(16'd4000, 8'd13, 0, 1'b0, 16, q, r, d);
    check("post_rst_q", q, 16'd307);
    check("post_rst_r", r, 8'd9);
    check("post_rst_dz", d, 0);

    for (int k = 0; k < 2000; k++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom);
      if (k % 97 == 0) b = 8'd0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run(a, b, $urandom_range(0, 2), 1'b1, (b == 0) ? 0 : 16, q, r, d);
      if (b == 0) begin
        eq = 16'hFFFF; er = a[7:0];
      end else begin
        eq = a / {8'd0, b}; er = 8'(a % {8'd0, b});
        check("rnd_identity", 32'(q) * 32'(b) + 32'(r), 32'(a));
        check("rnd_r_lt_b", (r < b), 1);
      end
      check("rnd_q", q, eq);
      check("rnd_r", r, er);
      check("rnd_dz", d, (b == 0));
    end

    @(posedge clk); #1;
    check("results_delivered", res_cnt, n_done);
    check("operands_accepted", acc_cnt, n_done + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
